// File: rtl/mem_arbiter_if.sv
// Bus bundle between the CPU fetch/load-store paths, the arbiter and the memory port.
// The arbiter connects through the slave modport; the surrounding environment uses master.
interface mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              If_Req;
    logic [ADDR_W-1:0] If_Addr;
    logic [DATA_W-1:0] If_Rdata;
    logic              If_Ack;

    logic              D_Req;
    logic              D_We;
    logic [ADDR_W-1:0] D_Addr;
    logic [DATA_W-1:0] D_Wdata;
    logic [DATA_W-1:0] D_Rdata;
    logic              D_Ack;

    logic              Mem_Req;
    logic              Mem_We;
    logic [ADDR_W-1:0] Mem_Addr;
    logic [DATA_W-1:0] Mem_Wdata;
    logic [DATA_W-1:0] Mem_Rdata;
    logic              Mem_Ready;

    logic              Err;
    logic              Err_Flag;

    modport slave (
        input  If_Req, If_Addr, D_Req, D_We, D_Addr, D_Wdata, Mem_Rdata, Mem_Ready,
        output If_Rdata, If_Ack, D_Rdata, D_Ack, Mem_Req, Mem_We, Mem_Addr, Mem_Wdata,
               Err, Err_Flag
    );

    modport master (
        output If_Req, If_Addr, D_Req, D_We, D_Addr, D_Wdata, Mem_Rdata, Mem_Ready,
        input  If_Rdata, If_Ack, D_Rdata, D_Ack, Mem_Req, Mem_We, Mem_Addr, Mem_Wdata,
               Err, Err_Flag
    );
endinterface

// File: rtl/mem_arbiter.sv
// Shares one memory port between instruction fetch and data load/store, with data
// priority, a fairness limit for starved fetches and a per-transaction timeout.
module mem_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int DATA_MAX = 4,
    parameter int TIMEOUT  = 16
) (
    input  logic          Clk,
    input  logic          Rst,
    mem_arbiter_if.slave  bus
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    localparam int CNT_W  = $clog2(TIMEOUT + 1);
    localparam int FAIR_W = $clog2(DATA_MAX + 1);

    logic [1:0]        state;
    logic              owner_d;
    logic [CNT_W-1:0]  tmo_cnt;
    logic [FAIR_W-1:0] fair_cnt;

    logic              fetch_forced;
    logic              grant_d;
    logic [ADDR_W-1:0] grant_addr;
    logic [DATA_W-1:0] cap_data;
    logic              tmo_hit;

    always_comb begin
        fetch_forced = bus.If_Req && (fair_cnt == FAIR_W'(DATA_MAX));
        grant_d      = bus.D_Req && !fetch_forced;
        grant_addr   = grant_d ? bus.D_Addr : bus.If_Addr;
        // Stores and timed-out transactions return zero to the requester.
        cap_data     = (bus.Mem_Ready && !bus.Mem_We) ? bus.Mem_Rdata : '0;
        tmo_hit      = (tmo_cnt == CNT_W'(TIMEOUT - 1));
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state        <= IDLE;
            owner_d      <= 1'b0;
            tmo_cnt      <= '0;
            fair_cnt     <= '0;
            bus.Mem_Req  <= 1'b0;
            bus.Mem_We   <= 1'b0;
            bus.Mem_Addr <= '0;
            bus.Mem_Wdata <= '0;
            bus.If_Rdata <= '0;
            bus.If_Ack   <= 1'b0;
            bus.D_Rdata  <= '0;
            bus.D_Ack    <= 1'b0;
            bus.Err      <= 1'b0;
            bus.Err_Flag <= 1'b0;
        end else begin
            bus.If_Ack <= 1'b0;
            bus.D_Ack  <= 1'b0;
            bus.Err    <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.If_Req || bus.D_Req) begin
                        state         <= BUSY;
                        owner_d       <= grant_d;
                        tmo_cnt       <= '0;
                        bus.Mem_Req   <= 1'b1;
                        bus.Mem_We    <= grant_d && bus.D_We;
                        bus.Mem_Addr  <= grant_addr;
                        bus.Mem_Wdata <= grant_d ? bus.D_Wdata : '0;
                        // Count data grants that made a waiting fetch wait longer.
                        if (!grant_d)
                            fair_cnt <= '0;
                        else if (bus.If_Req && (fair_cnt != FAIR_W'(DATA_MAX)))
                            fair_cnt <= fair_cnt + FAIR_W'(1);
                    end
                end
                BUSY: begin
                    tmo_cnt <= tmo_cnt + CNT_W'(1);
                    if (bus.Mem_Ready || tmo_hit) begin
                        state       <= RESP;
                        bus.Mem_Req <= 1'b0;
                        if (owner_d) begin
                            bus.D_Rdata <= cap_data;
                            bus.D_Ack   <= 1'b1;
                        end else begin
                            bus.If_Rdata <= cap_data;
                            bus.If_Ack   <= 1'b1;
                        end
                        if (!bus.Mem_Ready) begin
                            bus.Err      <= 1'b1;
                            bus.Err_Flag <= 1'b1;
                        end
                    end
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed vectors, corner-case sequences and a
// randomized run against a transaction-level model of the arbitration rules.
module tb_mem_arbiter;
    localparam int ADDR_W   = 32;
    localparam int DATA_W   = 32;
    localparam int DATA_MAX = 4;
    localparam int TIMEOUT  = 16;
    localparam logic [31:0] KEY = 32'hA5C3_5A3C;

    logic Clk = 1'b0;
    logic Rst = 1'b0;
    always #5 Clk = ~Clk;

    mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    mem_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DATA_MAX(DATA_MAX), .TIMEOUT(TIMEOUT)
    ) dut (
        .Clk(Clk),
        .Rst(Rst),
        .bus(bus)
    );

    typedef struct {
        bit          is_d;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] mem_rd;
        int          waits;
        logic [31:0] exp_rd;
        bit          exp_we;
        int          exp_lat;
    } vec_t;

    vec_t vecs[7];

    int          checks   = 0;
    int          failures = 0;
    int          mem_wait = 0;
    int          busy_n   = 0;
    logic [31:0] mem_data = '0;
    bit          rnd_idle = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Advance one cycle, sample just after the edge, then act as the memory for the next edge.
    task automatic tick();
        @(posedge Clk);
        #1;
        if (bus.Mem_Req) begin
            bus.Mem_Ready = (busy_n == mem_wait);
            bus.Mem_Rdata = (busy_n == mem_wait) ? mem_data : $urandom;
            busy_n++;
        end else begin
            busy_n        = 0;
            bus.Mem_Ready = rnd_idle ? 1'($urandom) : 1'b0;
            bus.Mem_Rdata = $urandom;
        end
    endtask

    task automatic run_one(input vec_t v, input string tag);
        int          c      = 0;
        int          mreq_n = 0;
        bit          got    = 0;
        bit          stable = 1;
        bit          both   = 0;
        logic [31:0] a0     = '0;
        logic [31:0] w0     = '0;
        tick();
        mem_wait = v.waits;
        mem_data = v.mem_rd;
        if (v.is_d) begin
            bus.D_Req = 1'b1; bus.D_We = v.we; bus.D_Addr = v.addr; bus.D_Wdata = v.wdata;
        end else begin
            bus.If_Req = 1'b1; bus.If_Addr = v.addr;
        end
        while (!got && c < 40) begin
            tick();
            c++;
            if (bus.Mem_Req) begin
                if (mreq_n == 0) begin
                    check({tag, " mem_addr"}, 64'(bus.Mem_Addr), 64'(v.addr));
                    check({tag, " mem_we"}, 64'(bus.Mem_We), 64'(v.exp_we));
                    if (v.exp_we) check({tag, " mem_wdata"}, 64'(bus.Mem_Wdata), 64'(v.wdata));
                    a0 = bus.Mem_Addr;
                    w0 = bus.Mem_Wdata;
                end else if (bus.Mem_Addr !== a0 || bus.Mem_Wdata !== w0) begin
                    stable = 0;
                end
                mreq_n++;
            end
            if (bus.If_Ack && bus.D_Ack) both = 1;
            if (bus.If_Ack || bus.D_Ack) begin
                got = 1;
                check({tag, " ack owner"}, 64'({bus.If_Ack, bus.D_Ack}), v.is_d ? 64'd1 : 64'd2);
                check({tag, " latency"}, 64'(c), 64'(v.exp_lat));
                check({tag, " rdata"}, 64'(v.is_d ? bus.D_Rdata : bus.If_Rdata), 64'(v.exp_rd));
                check({tag, " err"}, 64'(bus.Err), 64'd0);
                bus.D_Req  = 1'b0;
                bus.If_Req = 1'b0;
            end
        end
        check({tag, " ack seen"}, 64'(got), 64'd1);
        check({tag, " mem_req cycles"}, 64'(mreq_n), 64'(v.waits + 1));
        check({tag, " mem bus stable"}, 64'(stable), 64'd1);
        check({tag, " single ack"}, 64'(both), 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got running expected finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          c, td, ti, nreq, n;
        bit          got;
        logic [9:0]  order;
        bit          pi, pd, dwe, wd, hli, hld;
        logic [31:0] ia, da, dwd, ea, erd, li, ld;
        int          streak;

        bus.If_Req = 0; bus.If_Addr = '0;
        bus.D_Req = 0; bus.D_We = 0; bus.D_Addr = '0; bus.D_Wdata = '0;
        bus.Mem_Rdata = '0; bus.Mem_Ready = 0;

        vecs[0] = '{1'b1, 1'b0, 32'h0000_0040, 32'h0,         32'hDEAD_BEEF, 0, 32'hDEAD_BEEF, 1'b0, 2};
        vecs[1] = '{1'b1, 1'b1, 32'h0000_0044, 32'h1234_5678, 32'hFFFF_0000, 0, 32'h0,         1'b1, 2};
        vecs[2] = '{1'b0, 1'b0, 32'h0000_1000, 32'h0,         32'hCAFE_F00D, 0, 32'hCAFE_F00D, 1'b0, 2};
        vecs[3] = '{1'b1, 1'b0, 32'h0000_0080, 32'h0,         32'h0BAD_F00D, 3, 32'h0BAD_F00D, 1'b0, 5};
        vecs[4] = '{1'b0, 1'b0, 32'h0000_1004, 32'h0,         32'h1111_2222, 2, 32'h1111_2222, 1'b0, 4};
        vecs[5] = '{1'b1, 1'b1, 32'h0000_0088, 32'hA5A5_A5A5, 32'h7777_7777, 3, 32'h0,         1'b1, 5};
        vecs[6] = '{1'b0, 1'b0, 32'hFFFF_FFFC, 32'h0,         32'hFFFF_FFFF, 1, 32'hFFFF_FFFF, 1'b0, 3};

        // Reset state
        repeat (3) @(posedge Clk);
        #1;
        check("reset ctrl", 64'({bus.Mem_Req, bus.Mem_We, bus.If_Ack, bus.D_Ack, bus.Err, bus.Err_Flag}), 64'd0);
        check("reset rdata", 64'({bus.If_Rdata, bus.D_Rdata}), 64'd0);
        check("reset mem_addr", 64'(bus.Mem_Addr), 64'd0);
        Rst = 1'b1;
        tick(); tick();
        check("idle no mem_req", 64'(bus.Mem_Req), 64'd0);

        rnd_idle = 1'b1;
        for (int i = 0; i < 7; i++) run_one(vecs[i], $sformatf("vec%0d", i));

        // Contention: simultaneous store and fetch, data goes first
        tick();
        mem_wait = 0; mem_data = 32'h55AA_55AA;
        bus.D_Req = 1; bus.D_We = 1; bus.D_Addr = 32'h200; bus.D_Wdata = 32'h1234_5678;
        bus.If_Req = 1; bus.If_Addr = 32'h300;
        c = 0; td = -1; ti = -1; nreq = 0;
        while ((td < 0 || ti < 0) && c < 30) begin
            tick();
            c++;
            if (bus.Mem_Req && busy_n == 1) begin
                nreq++;
                if (nreq == 1) begin
                    check("cont first addr", 64'(bus.Mem_Addr), 64'h200);
                    check("cont first we", 64'(bus.Mem_We), 64'd1);
                    check("cont first wdata", 64'(bus.Mem_Wdata), 64'h1234_5678);
                end else begin
                    check("cont second addr", 64'(bus.Mem_Addr), 64'h300);
                    check("cont second we", 64'(bus.Mem_We), 64'd0);
                end
            end
            if (bus.D_Ack && bus.If_Ack) check("cont both acks", 64'd1, 64'd0);
            if (bus.D_Ack) begin td = c; bus.D_Req = 0; end
            if (bus.If_Ack) begin ti = c; bus.If_Req = 0; end
        end
        check("cont d_ack cycle", 64'(td), 64'd2);
        check("cont if_ack gap", 64'(ti - td), 64'd3);
        check("cont if_rdata", 64'(bus.If_Rdata), 64'h55AA_55AA);

        // Fairness: both held; expect D,D,D,D,I,D,D,D,D,I
        tick();
        mem_wait = 0; mem_data = 32'h0F0F_0F0F;
        bus.D_Req = 1; bus.D_We = 0; bus.D_Addr = 32'h1000;
        bus.If_Req = 1; bus.If_Addr = 32'h2000;
        order = '0; n = 0; c = 0;
        while (n < 10 && c < 100) begin
            tick();
            c++;
            if (bus.D_Ack || bus.If_Ack) begin
                order = {order[8:0], bus.If_Ack};
                n++;
                bus.D_Addr = bus.D_Addr + 32'd4;
                if (bus.If_Ack) bus.If_Addr = bus.If_Addr + 32'd4;
            end
        end
        bus.D_Req = 0; bus.If_Req = 0;
        check("fair grants", 64'(n), 64'd10);
        check("fair order", 64'(order), 64'b00_0010_0001);

        // Randomized traffic against the arbitration model
        pi = 0; pd = 0; dwe = 0; hli = 0; hld = 0; streak = 0;
        ia = '0; da = '0; dwd = '0; li = '0; ld = '0;
        for (int k = 0; k < 80; k++) begin
            if (!pi && $urandom_range(0, 2) != 0) begin pi = 1; ia = $urandom; end
            if (!pd && ($urandom_range(0, 2) != 0 || !pi)) begin
                pd = 1; dwe = 1'($urandom); da = $urandom; dwd = $urandom;
            end
            bus.If_Req = pi; bus.If_Addr = ia;
            bus.D_Req = pd; bus.D_We = dwe; bus.D_Addr = da; bus.D_Wdata = dwd;
            // Data wins unless the fetch has already waited through DATA_MAX data grants.
            wd  = pd && !(pi && streak >= DATA_MAX);
            ea  = wd ? da : ia;
            erd = (wd && dwe) ? 32'h0 : (ea ^ KEY);
            mem_wait = $urandom_range(0, 3);
            mem_data = ea ^ KEY;
            c = 0; got = 0;
            while (!got && c < 30) begin
                tick();
                c++;
                if (bus.Mem_Req && busy_n == 1) begin
                    check("rand mem_addr", 64'(bus.Mem_Addr), 64'(ea));
                    check("rand mem_we", 64'(bus.Mem_We), 64'(wd && dwe));
                    if (wd && dwe) check("rand mem_wdata", 64'(bus.Mem_Wdata), 64'(dwd));
                end
                if (bus.If_Ack || bus.D_Ack) begin
                    got = 1;
                    check("rand ack owner", 64'({bus.If_Ack, bus.D_Ack}), wd ? 64'd1 : 64'd2);
                    check("rand latency", 64'(c), 64'(mem_wait + 3));
                    check("rand rdata", 64'(wd ? bus.D_Rdata : bus.If_Rdata), 64'(erd));
                    if (wd && hli) check("rand if_rdata hold", 64'(bus.If_Rdata), 64'(li));
                    if (!wd && hld) check("rand d_rdata hold", 64'(bus.D_Rdata), 64'(ld));
                    check("rand err", 64'(bus.Err), 64'd0);
                end
            end
            check("rand ack seen", 64'(got), 64'd1);
            if (wd) begin
                pd = 0; ld = erd; hld = 1;
                if (pi && streak < DATA_MAX) streak++;
            end else begin
                pi = 0; li = erd; hli = 1; streak = 0;
            end
            bus.If_Req = pi; bus.D_Req = pd;
        end
        bus.If_Req = 0; bus.D_Req = 0;

        // Timeout on a fetch with no Mem_Ready
        tick();
        mem_wait = 1000;
        bus.If_Req = 1; bus.If_Addr = 32'h500;
        c = 0; got = 0; nreq = 0;
        while (!got && c < 40) begin
            tick();
            c++;
            if (bus.Mem_Req) nreq++;
            if (bus.If_Ack || bus.D_Ack) begin
                got = 1;
                check("tmo ack owner", 64'({bus.If_Ack, bus.D_Ack}), 64'd2);
                check("tmo err", 64'(bus.Err), 64'd1);
                check("tmo rdata", 64'(bus.If_Rdata), 64'd0);
                check("tmo err_flag", 64'(bus.Err_Flag), 64'd1);
                check("tmo latency", 64'(c), 64'(TIMEOUT + 1));
                bus.If_Req = 0;
            end
        end
        check("tmo ack seen", 64'(got), 64'd1);
        check("tmo mem_req cycles", 64'(nreq), 64'(TIMEOUT));
        tick(); tick(); tick();
        check("tmo err pulse", 64'(bus.Err), 64'd0);
        check("tmo flag sticky", 64'(bus.Err_Flag), 64'd1);
        run_one(vecs[0], "post_tmo");
        check("flag after ok txn", 64'(bus.Err_Flag), 64'd1);

        // Asynchronous reset during BUSY
        tick();
        mem_wait = 1000;
        bus.D_Req = 1; bus.D_We = 0; bus.D_Addr = 32'h600;
        tick(); tick(); tick();
        check("rst pre busy", 64'(bus.Mem_Req), 64'd1);
        #2 Rst = 1'b0;
        #1;
        check("rst async ctrl", 64'({bus.Mem_Req, bus.If_Ack, bus.D_Ack, bus.Err_Flag}), 64'd0);
        check("rst async rdata", 64'({bus.If_Rdata, bus.D_Rdata}), 64'd0);
        bus.D_Req = 0;
        @(posedge Clk);
        #1;
        check("rst held no ack", 64'({bus.Mem_Req, bus.If_Ack, bus.D_Ack}), 64'd0);
        Rst = 1'b1;
        run_one(vecs[3], "post_rst");
        check("post_rst flag", 64'(bus.Err_Flag), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one unified memory port between the CPU instruction-fetch path and the data load/store path.
- Arbitrates requests and sequences each memory transaction through a request/ready handshake.
- Returns read data and a one-cycle acknowledge to the winning requester.
- Sits between the CPU datapath (PC/fetch and load/store unit) and the single-ported memory model.

Parameters:
- ADDR_W, 32, address width of all address ports.
- DATA_W, 32, data width of all data ports.
- DATA_MAX, 4, max consecutive data grants while a fetch is pending before fetch is forced.
- TIMEOUT, 16, cycles of Mem_Req without Mem_Ready before the transaction is aborted with error.

Ports:
- Clk  in  1  system clock, rising edge.
- Rst  in  1  asynchronous, active-low reset (0 = reset).
- If_Req  in  1  fetch request; held until If_Ack.
- If_Addr  in  ADDR_W  fetch address; stable while If_Req=1.
- If_Rdata  out  DATA_W  fetched word; valid when If_Ack=1.
- If_Ack  out  1  one-cycle fetch completion pulse.
- D_Req  in  1  data request; held until D_Ack.
- D_We  in  1  1 = store, 0 = load.
- D_Addr  in  ADDR_W  data address.
- D_Wdata  in  DATA_W  store data.
- D_Rdata  out  DATA_W  load data; valid when D_Ack=1.
- D_Ack  out  1  one-cycle data completion pulse.
- Mem_Req  out  1  memory access request.
- Mem_We  out  1  memory write enable.
- Mem_Addr  out  ADDR_W  memory address.
- Mem_Wdata  out  DATA_W  memory write data.
- Mem_Rdata  in  DATA_W  memory read data; sampled when Mem_Ready=1.
- Mem_Ready  in  1  memory completion; valid only while Mem_Req=1.
- Err  out  1  one-cycle pulse, coincident with the Ack of a timed-out transaction.
- Err_Flag  out  1  sticky timeout indicator; cleared only by reset.

Behaviour:
- Reset (Rst=0, asynchronous):
  - State goes to IDLE.
  - All outputs go to 0, including Rdata buses, Err_Flag, fairness counter and timeout counter.
  - Any in-flight transaction is aborted with no Ack; requesters must re-issue after reset.
- FSM states:
  - IDLE: arbitrate.
    - Nothing requested: stay in IDLE.
    - Otherwise latch the winner's address, write data and write enable into the Mem_* registers, record the owner, go to BUSY.
  - BUSY: Mem_Req=1, Mem_* outputs held constant.
    - Timeout counter increments each BUSY cycle.
    - Mem_Ready=1: capture Mem_Rdata into the owner's Rdata register (stores capture 0), go to RESP.
    - Counter reaches TIMEOUT-1 without Mem_Ready: Rdata=0, set the err pending bit, go to RESP.
  - RESP: Mem_Req=0; owner's Ack=1 for exactly one cycle.
    - Err=1 in the same cycle if the err pending bit is set; Err_Flag is set.
    - Unconditionally go to IDLE.
- Arbitration (IDLE only):
  - Data has priority over fetch.
  - Exception: when If_Req=1 and the fairness counter equals DATA_MAX, fetch wins.
  - Fairness counter increments on each data grant made while If_Req=1; clears on any fetch grant; saturates at DATA_MAX.
- Latency:
  - Request seen in IDLE at cycle 0 gives Mem_Req=1 in cycle 1.
  - With Mem_Ready=1 in cycle 1, Ack=1 in cycle 2 and state is IDLE in cycle 3.
  - Minimum transaction length is 3 cycles; each wait cycle adds 1.
- Handshake rules:
  - Requester holds Req, address and data stable until it samples Ack=1, then may drop or change them.
  - Req changes in cycles where the requester is not granted are ignored.
  - Rdata holds its last value until the next Ack to the same requester.
- Mem_Ready outside BUSY is ignored.
- Simultaneous requests: exactly one Ack per transaction, never both Acks in the same cycle.
- Mem_We is 0 for all fetch transactions.

Test Plan:
- Single load, zero-wait: D_Req=1, D_We=0, D_Addr=0x40; Mem_Ready=1 in cycle 1 with Mem_Rdata=0xDEADBEEF -> Mem_Req high in cycle 1 only, D_Ack in cycle 2 with D_Rdata=0xDEADBEEF, If_Ack stays 0.
- Contention: If_Req and D_Req both raised in the same cycle, D_We=1, D_Wdata=0x12345678 -> data served first (Mem_We=1, Mem_Addr=D_Addr), then fetch; If_Ack exactly 3 cycles after D_Ack with zero-wait memory.
- Fairness: D_Req held continuously for 6 accesses and If_Req held -> grant order D,D,D,D,I,D; counter back to 0 after the fetch grant.
- Wait states: Mem_Ready delayed 3 cycles -> Mem_Req high for 4 cycles, Mem_Addr/Mem_Wdata constant throughout, Ack in the cycle after Mem_Ready.
- Timeout: Mem_Ready never asserted on a fetch -> Mem_Req high for 16 cycles, then If_Ack=1 with Err=1 and If_Rdata=0; Err_Flag stays 1 until Rst=0.
- Reset mid-operation: Rst driven low during BUSY -> Mem_Req, Acks and Err_Flag drop to 0 immediately (asynchronous) with no Ack issued; after release, a re-issued request completes normally.
